// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: PC, imem req/ack, instr valid/ready, HALT detect.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
`ifndef InstrWidth
`define InstrWidth 16
`endif
`ifndef OP_HALT
`define OP_HALT 4'hF
`endif
`ifndef OP_ADD
`define OP_ADD 4'h1
`endif

module fetch_unit #(
  parameter int                    ADDR_WIDTH     = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0,
  parameter int                    TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_ack,
  input  logic [`InstrWidth-1:0] imem_rdata,
  output logic [`InstrWidth-1:0] instr,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  input  logic                   branch_en,
  input  logic [ADDR_WIDTH-1:0]  branch_target,
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic                   halted,
  output logic                   fetch_err
);
  localparam logic [1:0] FETCH  = 2'd0;
  localparam logic [1:0] ISSUE  = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  logic [1:0] state;
  logic       ack_ok, is_halt, timeout;

  // An ack only counts while a request is outstanding.
  assign ack_ok    = imem_req && imem_ack;
  assign is_halt   = (imem_rdata[`InstrWidth-1:12] == `OP_HALT);
  assign imem_addr = pc;

`ifdef FETCH_TIMEOUT_EN
  localparam int              CW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   LIMIT = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] wd_cnt;

  // Fires on the last waiting cycle; a same-cycle ack wins.
  assign timeout = (state == FETCH) && imem_req && !imem_ack && (wd_cnt == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          wd_cnt <= '0;
    else if (state != FETCH || ack_ok)   wd_cnt <= '0;
    else if (imem_req)                   wd_cnt <= wd_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       fetch_err <= 1'b0;
    else if (timeout) fetch_err <= 1'b1;
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign timeout   = 1'b0;
  assign fetch_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      instr       <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (ack_ok) begin
            instr    <= imem_rdata;
            imem_req <= 1'b0;
            if (is_halt) begin
              state  <= HALTED;
              halted <= 1'b1;
            end else begin
              state       <= ISSUE;
              instr_valid <= 1'b1;
            end
          end else if (timeout) begin
            state    <= HALTED;
            halted   <= 1'b1;
            imem_req <= 1'b0;
          end else begin
            imem_req <= 1'b1;
          end
        end
        ISSUE: begin
          if (instr_ready) begin
            pc          <= branch_en ? branch_target : pc + 1'b1;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= FETCH;
          end
        end
        default: begin
          // Terminal until reset; instr keeps the HALT word.
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          halted      <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed, scoreboard-based bench for fetch_unit (two instances: RESET_PC 0 and FFFF).
`ifndef InstrWidth
`define InstrWidth 16
`endif
`ifndef OP_HALT
`define OP_HALT 4'hF
`endif
`ifndef OP_ADD
`define OP_ADD 4'h1
`endif

module tb_fetch_unit;
  localparam int AW = 16;
  localparam int IW = `InstrWidth;
`ifdef FETCH_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0, rst2_n = 1'b0;
  logic          imem_req, imem_ack, instr_valid, instr_ready, branch_en, halted, fetch_err;
  logic [AW-1:0] imem_addr, branch_target, pc;
  logic [IW-1:0] imem_rdata, instr;
  logic          req2, ack2, valid2, ready2, br2_en, halted2, err2;
  logic [AW-1:0] addr2, br2_tgt, pc2;
  logic [IW-1:0] rdata2, instr2;

  fetch_unit #(.ADDR_WIDTH(AW), .RESET_PC(16'h0000), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .branch_en(branch_en),
    .branch_target(branch_target), .pc(pc), .halted(halted), .fetch_err(fetch_err));

  fetch_unit #(.ADDR_WIDTH(AW), .RESET_PC(16'hFFFF), .TIMEOUT_CYCLES(TO)) dut2 (
    .clk(clk), .rst_n(rst2_n), .imem_req(req2), .imem_addr(addr2),
    .imem_ack(ack2), .imem_rdata(rdata2), .instr(instr2),
    .instr_valid(valid2), .instr_ready(ready2), .branch_en(br2_en),
    .branch_target(br2_tgt), .pc(pc2), .halted(halted2), .fetch_err(err2));

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  logic [IW-1:0] exp_q[$];
  logic [AW-1:0] addr_log[$];
  logic          vld_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0; branch_en = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Memory acks every request at once; accepted words are scoreboarded.
  task automatic run(input int n, input int halt_at, input logic rdy);
    for (int c = 0; c < n; c++) begin
      imem_ack = 1'b0;
      if (imem_req) begin
        addr_log.push_back(imem_addr);
        imem_ack = 1'b1;
        if (int'(imem_addr) == halt_at) imem_rdata = {`OP_HALT, 12'h000};
        else begin
          imem_rdata = {`OP_ADD, imem_addr[11:0]};
          exp_q.push_back(imem_rdata);
        end
      end
      instr_ready = rdy;
      vld_log.push_back(instr_valid);
      if (instr_valid && rdy)
        chk("sb_instr", instr, (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF);
      @(negedge clk);
    end
    imem_ack = 1'b0; instr_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    imem_ack = 0; imem_rdata = '0; instr_ready = 0; branch_en = 0; branch_target = '0;
    ack2 = 0; rdata2 = '0; ready2 = 0; br2_en = 0; br2_tgt = '0;

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_err", fetch_err, 0);
    chk("rst_pc", pc, 0);
    chk("rst_instr", instr, 0);
    chk("rst2_pc", pc2, 16'hFFFF);
    chk("rst2_instr", instr2, 0);
    chk("rst2_halted", halted2, 0);
    chk("rst2_err", err2, 0);

    // Streaming fetch, ready held high
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 0);
    run(8, -1, 1'b1);
    for (int i = 0; i < 4; i++) chk("addr_seq", (addr_log.size() > i) ? addr_log[i] : 16'hBAD0, i);
    for (int i = 0; i < 8; i++) chk("valid_pattern", vld_log[i], (i % 2 == 1) ? 1 : 0);
    chk("stream_halted", halted, 0);
    chk("stream_sb_empty", exp_q.size(), 0);

    // HALT word at address 2
    addr_log.delete(); vld_log.delete(); exp_q.delete();
    do_reset();
    run(5, 2, 1'b1);
    chk("halt_flag", halted, 1);
    chk("halt_valid", instr_valid, 0);
    chk("halt_instr", instr, {`OP_HALT, 12'h000});
    chk("halt_sb_empty", exp_q.size(), 0);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      imem_ack = 1'b1; instr_ready = 1'b1;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b1) ok = 1'b0;
      @(negedge clk);
    end
    imem_ack = 1'b0; instr_ready = 1'b0;
    chk("halt_quiet_20", ok, 1);
    chk("halt_pc", pc, 2);

    // Stall in ISSUE, then branch on accept
    do_reset();
    imem_ack = 1'b1; imem_rdata = 16'h1123;
    @(negedge clk);
    imem_ack = 1'b0; instr_ready = 1'b0;
    branch_en = 1'b1; branch_target = 16'h0099;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (instr_valid !== 1'b1 || instr !== 16'h1123 || imem_req !== 1'b0) ok = 1'b0;
      @(negedge clk);
    end
    chk("stall_stable", ok, 1);
    chk("stall_pc", pc, 0);
    instr_ready = 1'b1; branch_target = 16'h0040;
    @(negedge clk);
    instr_ready = 1'b0; branch_en = 1'b0;
    chk("branch_req", imem_req, 1);
    chk("branch_addr", imem_addr, 16'h0040);
    chk("branch_valid", instr_valid, 0);

    // PC wrap on dut2
    rst2_n = 1'b1;
    @(negedge clk);
    chk("wrap_first_addr", addr2, 16'hFFFF);
    ack2 = 1'b1; rdata2 = {`OP_ADD, 12'h001};
    @(negedge clk);
    ack2 = 1'b0;
    chk("wrap_valid", valid2, 1);
    ready2 = 1'b1;
    @(negedge clk);
    ready2 = 1'b0;
    chk("wrap_req", req2, 1);
    chk("wrap_addr", addr2, 16'h0000);

    // Asynchronous reset with ack pending
    do_reset();
    @(negedge clk);
    chk("midfetch_req", imem_req, 1);
    imem_ack = 1'b1; imem_rdata = {`OP_ADD, 12'h0AA};
    #2 rst_n = 1'b0;
    #1;
    chk("async_req", imem_req, 0);
    chk("async_valid", instr_valid, 0);
    chk("async_instr", instr, 0);
    chk("async_pc", pc, 0);
    @(negedge clk);
    imem_ack = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("restart_req", imem_req, 1);
    chk("restart_addr", imem_addr, 0);
    chk("restart_valid", instr_valid, 0);

`ifdef FETCH_TIMEOUT_EN
    // Watchdog: no ack for 8 request cycles
    do_reset();
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (halted !== 1'b0 || fetch_err !== 1'b0) ok = 1'b0;
      @(negedge clk);
    end
    chk("to_not_early", ok, 1);
    chk("to_err", fetch_err, 1);
    chk("to_halted", halted, 1);
    chk("to_req", imem_req, 0);
    // Ack on the 8th cycle wins
    do_reset();
    chk("to_err_cleared", fetch_err, 0);
    for (int i = 0; i < 7; i++) @(negedge clk);
    imem_ack = 1'b1; imem_rdata = {`OP_ADD, 12'h008};
    @(negedge clk);
    imem_ack = 1'b0;
    chk("to_late_valid", instr_valid, 1);
    chk("to_late_err", fetch_err, 0);
    chk("to_late_halted", halted, 0);
`else
    chk("no_wd_err", fetch_err, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch sequencer feeding the control decoder: holds the program counter, reads instruction words from instruction memory over a req/ack handshake, and presents each word on `instr` with a valid/ready handshake to the control/execute stage. It detects `OP_HALT` at fetch time and stops fetching until reset. It is the producer end of the `instr` bus that the control block consumes.

## Interface
- `ADDR_WIDTH`, 16, width of `pc` and `imem_addr`.
- `RESET_PC`, 0, PC value loaded on reset.
- `TIMEOUT_CYCLES`, 255, fetch watchdog limit; used only with `FETCH_TIMEOUT_EN`.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active low.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  ADDR_WIDTH  fetch address; equals `pc`.
- `imem_ack`  in  1  memory has valid `imem_rdata` this cycle.
- `imem_rdata`  in  `InstrWidth`  fetched instruction word.
- `instr`  out  `InstrWidth`  instruction to control decoder.
- `instr_valid`  out  1  `instr` is valid for issue.
- `instr_ready`  in  1  consumer accepts `instr` this cycle.
- `branch_en`  in  1  redirect PC; sampled only on an accept cycle.
- `branch_target`  in  ADDR_WIDTH  redirect address.
- `pc`  out  ADDR_WIDTH  address of the current or next instruction.
- `halted`  out  1  `OP_HALT` fetched, or watchdog fired.
- `fetch_err`  out  1  sticky watchdog error.

## Operation
- Opcode field: `instr[`InstrWidth-1:12]`. It is compared against `OP_HALT` from `defs.svh`.
- Reset values: `pc`=RESET_PC, `imem_req`=0, `instr`=0, `instr_valid`=0, `halted`=0, `fetch_err`=0, state=FETCH.
- States:
  - FETCH
    - `imem_req`=1 and `imem_addr`=`pc`. Both are held stable until `imem_ack`.
    - On ack with a non-HALT word: latch `imem_rdata` into `instr` and go to ISSUE.
    - On ack with a HALT word: latch it into `instr` and go to HALTED. `pc` is not advanced.
  - ISSUE
    - `imem_req`=0, `instr_valid`=1.
    - On `instr_ready`=1: `pc` <= `branch_en` ? `branch_target` : `pc`+1. `instr_valid` drops and the state returns to FETCH.
  - HALTED
    - Terminal until `rst_n` is asserted.
    - `halted`=1, `imem_req`=0, `instr_valid`=0. `instr` keeps the HALT word.
- `imem_ack` is ignored when `imem_req`=0.
- `pc`+1 wraps modulo 2^ADDR_WIDTH (max → 0) with no flag.
- `branch_en` outside an accept cycle has no effect.
- `instr` is stable for as long as `instr_valid`=1.

## Timing
- All outputs are registered.
- `imem_req` rises in the first clock edge after `rst_n` deasserts.
- Ack in cycle N: `instr`/`instr_valid` update at edge N+1.
- Accept in cycle M: `imem_req`=1 with the new `pc` from edge M+1.
- Best-case throughput: one instruction per 2 cycles (ack and ready each asserted immediately).
- HALT ack in cycle N: `halted`=1 from edge N+1; `instr_valid` never asserts for the HALT word.
- `rst_n` low mid-fetch or mid-issue: all outputs go to their reset values immediately (asynchronous). Any in-flight ack is discarded.

## Configuration
- `FETCH_TIMEOUT_EN` defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) increments each FETCH cycle with `imem_ack`=0, and clears on ack or on entering FETCH.
  - When the count reaches TIMEOUT_CYCLES without ack: `fetch_err`=1 (sticky) and the state goes to HALTED (`halted`=1) at the next edge.
  - An ack in the same cycle the limit is reached takes priority, and the fetch completes normally.
- Not defined:
  - No counter is built and `fetch_err` is tied to 0.
  - FETCH waits for ack indefinitely and `TIMEOUT_CYCLES` is unused.

## Test plan
- Reset, RESET_PC=0, memory acks every request immediately with {`OP_ADD`,12'h001}, ready held 1:
  - `imem_addr` sequence 0,1,2,3.
  - `instr_valid` asserts every 2nd cycle.
  - `halted`=0.
- Ack at addr 2 returns {`OP_HALT`,12'b0}:
  - `halted`=1 one edge later and `instr_valid` stays 0.
  - `imem_req` stays 0 for 20 cycles and `pc`=2.
- Ready held 0 for 5 cycles while in ISSUE:
  - `instr` and `instr_valid` stay stable and no new request is made.
  - On ready=1 with `branch_en`=1, `branch_target`=16'h0040: next `imem_addr`=16'h0040.
- RESET_PC=16'hFFFF with a non-HALT word accepted: next `imem_addr`=16'h0000.
- `rst_n` pulsed low while `imem_req`=1 and ack is pending: outputs return to reset values asynchronously, and fetch restarts at RESET_PC.
- With `FETCH_TIMEOUT_EN`, TIMEOUT_CYCLES=8, ack never given:
  - `fetch_err`=1 and `halted`=1 after 8 FETCH cycles.
  - A repeat run with ack in the 8th cycle completes normally with `fetch_err`=0.
